counter_seq_ctrl: RTL and testbench

- Sequencer for the team's 8-bit free-running counter datapath, which has synchronous `clr`, a one-cycle `start` pulse and an 8-bit `q`.
- Runs a programmed number of count passes from 0 up to a programmed limit.
- Each pass: clear the counter, start it, wait for `q` to reach the limit.
- Reports completion, and detects a stalled counter via a watchdog.
- Sits between software/control logic (`go`/`abort`) and one counter instance.

---
 rtl/counter_seq_ctrl.sv | 159 +++++++++++++++
 tb/tb_counter_seq_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_seq_ctrl.sv
// ---------------------------------------------------------------------------
// counter_seq_ctrl
//
// Sequencer for an 8-bit free-running counter datapath. On an accepted `go`
// it runs `reps` passes, where each pass clears the counter, pulses its start
// strobe and waits for the returned count to reach `limit`. A watchdog aborts
// the run with `err` if the count stops moving while waiting.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   go         in   run request, sampled only in IDLE
//   abort      in   terminate current run, sampled in every non-IDLE state
//   limit      in   terminal count, latched on accepted go
//   reps       in   number of passes, latched on accepted go (0 acts as 1)
//   cnt_q      in   count value returned by the counter
//   cnt_clr    out  clear strobe to the counter
//   cnt_start  out  start strobe to the counter
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse on normal completion
//   err        out  sticky error, cleared by the next accepted go
//   rep_cnt    out  passes completed in the current run
// ---------------------------------------------------------------------------
module counter_seq_ctrl #(
    parameter int WIDTH    = 8,
    parameter int REP_W    = 4,
    parameter int WDOG_CYC = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic             abort,
    input  logic [WIDTH-1:0] limit,
    input  logic [REP_W-1:0] reps,
    input  logic [WIDTH-1:0] cnt_q,
    output logic             cnt_clr,
    output logic             cnt_start,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [REP_W-1:0] rep_cnt
);

    localparam int WD_W = 8;
    localparam logic [WD_W-1:0] WDOG_LAST = WD_W'(WDOG_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_START,
        S_WAIT,
        S_FIN,
        S_ABRT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic [REP_W-1:0] reps_q, reps_d;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [WD_W-1:0]  wdog_q, wdog_d;
    logic [WIDTH-1:0] prev_cnt_q;
    logic             err_q, err_d;

    logic [REP_W:0]   rep_next;
    logic [REP_W:0]   reps_eff;

    // One extra bit so the pass-count comparison cannot wrap.
    assign rep_next = {1'b0, rep_cnt_q} + (REP_W+1)'(1);
    assign reps_eff = (reps_q == '0) ? (REP_W+1)'(1) : {1'b0, reps_q};

    always_comb begin
        state_d   = state_q;
        limit_d   = limit_q;
        reps_d    = reps_q;
        rep_cnt_d = rep_cnt_q;
        wdog_d    = wdog_q;
        err_d     = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (go) begin
                    if (limit != '0) begin
                        state_d   = S_CLR;
                        limit_d   = limit;
                        reps_d    = reps;
                        rep_cnt_d = '0;
                        err_d     = 1'b0;
                    end else begin
                        // A zero limit could never terminate a pass.
                        err_d = 1'b1;
                    end
                end
            end
            S_CLR: begin
                state_d = abort ? S_ABRT : S_START;
            end
            S_START: begin
                state_d = abort ? S_ABRT : S_WAIT;
                wdog_d  = '0;
            end
            S_WAIT: begin
                // Priority: abort, then match, then watchdog.
                if (abort) begin
                    state_d = S_ABRT;
                end else if (cnt_q == limit_q) begin
                    rep_cnt_d = rep_next[REP_W-1:0];
                    state_d   = (rep_next >= reps_eff) ? S_FIN : S_CLR;
                end else if (cnt_q == prev_cnt_q) begin
                    if (wdog_q == WDOG_LAST) begin
                        err_d   = 1'b1;
                        state_d = S_ABRT;
                    end else begin
                        wdog_d = wdog_q + WD_W'(1);
                    end
                end else begin
                    wdog_d = '0;
                end
            end
            S_FIN:   state_d = S_IDLE;
            S_ABRT:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, latched run parameters and Moore outputs decoded from the next
    // state so every output lines up with the state it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            limit_q    <= '0;
            reps_q     <= '0;
            rep_cnt_q  <= '0;
            wdog_q     <= '0;
            prev_cnt_q <= '0;
            err_q      <= 1'b0;
            cnt_clr    <= 1'b0;
            cnt_start  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            rep_cnt    <= '0;
        end else begin
            state_q    <= state_d;
            limit_q    <= limit_d;
            reps_q     <= reps_d;
            rep_cnt_q  <= rep_cnt_d;
            wdog_q     <= wdog_d;
            prev_cnt_q <= cnt_q;
            err_q      <= err_d;
            cnt_clr    <= (state_d == S_CLR) || (state_d == S_FIN) || (state_d == S_ABRT);
            cnt_start  <= (state_d == S_START);
            busy       <= (state_d != S_IDLE);
            done       <= (state_d == S_FIN);
            err        <= err_d;
            rep_cnt    <= rep_cnt_d;
        end
    end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_counter_seq_ctrl
//
// Drives counter_seq_ctrl against a small behavioural model of the 8-bit
// counter (clear, start, count, optional stall at a chosen value). A table of
// per-cycle vectors covers a full single pass; hand-written sequences cover
// multi-pass runs, rejected requests, aborts, the watchdog and mid-run reset.
// ---------------------------------------------------------------------------
module tb_counter_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       go = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] limit = 8'd0;
    logic [3:0] reps = 4'd0;
    logic [7:0] cnt_q;
    logic       cnt_clr, cnt_start, busy, done, err;
    logic [3:0] rep_cnt;

    logic       run;
    logic       stall_en = 1'b0;
    logic [7:0] stall_val = 8'd0;

    int n_pass = 0;
    int n_total = 0;

    counter_seq_ctrl #(.WIDTH(8), .REP_W(4), .WDOG_CYC(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .go        (go),
        .abort     (abort),
        .limit     (limit),
        .reps      (reps),
        .cnt_q     (cnt_q),
        .cnt_clr   (cnt_clr),
        .cnt_start (cnt_start),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rep_cnt   (rep_cnt)
    );

    always #5 clk = ~clk;

    // Counter model: synchronous clear, start arms counting, optional stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
            run   <= 1'b0;
        end else if (cnt_clr) begin
            cnt_q <= 8'd0;
            run   <= 1'b0;
        end else if (cnt_start) begin
            run <= 1'b1;
        end else if (run && !(stall_en && cnt_q == stall_val)) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    typedef struct {
        logic       g;
        logic       a;
        logic [7:0] lim;
        logic [3:0] rp;
        logic [8:0] exp;
    } vec_t;

    vec_t vt[10];

    function automatic vec_t mk(input logic g, input logic a, input logic [7:0] l,
                                input logic [3:0] r, input logic [4:0] flags,
                                input logic [3:0] rc);
        vec_t v;
        v.g   = g;
        v.a   = a;
        v.lim = l;
        v.rp  = r;
        v.exp = {flags, rc};
        return v;
    endfunction

    // {cnt_clr, cnt_start, busy, done, err, rep_cnt}
    function automatic logic [8:0] dut_outs();
        return {cnt_clr, cnt_start, busy, done, err, rep_cnt};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to_idle(input string nm, output int dones);
        dones = 0;
        for (int c = 0; c < 500; c++) begin
            if (!busy) break;
            if (done) dones++;
            step();
        end
        chk({nm, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  starts, dones;
        logic ok, seen_done;

        // Single pass limit=5 reps=1, one vector per cycle.
        vt[0] = mk(1, 0, 8'd5, 4'd1, 5'b10100, 4'd0); // CLR
        vt[1] = mk(0, 0, 8'd5, 4'd1, 5'b01100, 4'd0); // START
        vt[2] = mk(0, 0, 8'd5, 4'd1, 5'b00100, 4'd0); // WAIT q=0
        vt[3] = mk(0, 0, 8'd5, 4'd1, 5'b00100, 4'd0); // q=1
        vt[4] = mk(0, 0, 8'd5, 4'd1, 5'b00100, 4'd0); // q=2
        vt[5] = mk(0, 0, 8'd5, 4'd1, 5'b00100, 4'd0); // q=3
        vt[6] = mk(0, 0, 8'd5, 4'd1, 5'b00100, 4'd0); // q=4
        vt[7] = mk(0, 0, 8'd5, 4'd1, 5'b00100, 4'd0); // q=5
        vt[8] = mk(0, 0, 8'd5, 4'd1, 5'b10110, 4'd1); // FIN
        vt[9] = mk(0, 0, 8'd5, 4'd1, 5'b00000, 4'd1); // IDLE

        // Reset
        #2;
        chk("reset_outs", 32'(dut_outs()), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("post_reset_idle", 32'(dut_outs()), 32'd0);

        for (int i = 0; i < 10; i++) begin
            go    = vt[i].g;
            abort = vt[i].a;
            limit = vt[i].lim;
            reps  = vt[i].rp;
            step();
            chk($sformatf("vec%0d", i), 32'(dut_outs()), 32'(vt[i].exp));
        end
        go = 1'b0;

        // Three passes of limit=3
        go = 1'b1; limit = 8'd3; reps = 4'd3;
        step();
        go = 1'b0;
        starts = 0;
        dones = 0;
        for (int c = 0; c < 200; c++) begin
            if (!busy) break;
            if (cnt_clr && cnt_start) chk("t2_strobe_excl", 32'd1, 32'd0);
            if (cnt_start) begin
                chk("t2_rep_at_start", 32'(rep_cnt), 32'(starts));
                starts++;
            end
            if (done) begin
                dones++;
                chk("t2_rep_at_done", 32'(rep_cnt), 32'd3);
            end
            step();
        end
        chk("t2_idle", 32'(busy), 32'd0);
        chk("t2_starts", 32'(starts), 32'd3);
        chk("t2_dones", 32'(dones), 32'd1);
        chk("t2_rep_final", 32'(rep_cnt), 32'd3);

        // Rejected zero limit, then a good run with reps=0 acting as 1
        go = 1'b1; limit = 8'd0; reps = 4'd2;
        step();
        go = 1'b0;
        chk("t3_reject", 32'(dut_outs()), 32'({5'b00001, 4'd3}));
        step();
        chk("t3_reject_hold", 32'(dut_outs()), 32'({5'b00001, 4'd3}));
        go = 1'b1; limit = 8'd4; reps = 4'd0;
        step();
        go = 1'b0;
        chk("t3_accept", 32'(dut_outs()), 32'({5'b10100, 4'd0}));
        run_to_idle("t3", dones);
        chk("t3_dones", 32'(dones), 32'd1);
        chk("t3_rep", 32'(rep_cnt), 32'd1);
        chk("t3_err", 32'(err), 32'd0);

        // Abort at q=50 of limit=200; a go at q=5 must be ignored
        go = 1'b1; limit = 8'd200; reps = 4'd1;
        step();
        go = 1'b0;
        limit = 8'd10; reps = 4'd5;
        ok = 1'b0;
        seen_done = 1'b0;
        for (int c = 0; c < 400; c++) begin
            go = (cnt_q == 8'd5);
            if (done) seen_done = 1'b1;
            if (cnt_q == 8'd50) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        go = 1'b0;
        chk("t4_reach50", 32'(ok), 32'd1);
        chk("t4_no_done", 32'(seen_done), 32'd0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t4_abrt", 32'(dut_outs()), 32'({5'b10100, 4'd0}));
        step();
        chk("t4_idle", 32'(dut_outs()), 32'd0);

        // go+abort in IDLE (go wins), then abort coinciding with a match
        go = 1'b1; abort = 1'b1; limit = 8'd5; reps = 4'd2;
        step();
        go = 1'b0; abort = 1'b0;
        chk("t5_go_wins", 32'(dut_outs()), 32'({5'b10100, 4'd0}));
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (cnt_q == 8'd5 && busy && !cnt_clr && !cnt_start) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        chk("t5_reach_match", 32'(ok), 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t5_abort_over_match", 32'(dut_outs()), 32'({5'b10100, 4'd0}));
        step();
        chk("t5_idle", 32'(dut_outs()), 32'd0);

        // Abort while in CLR
        go = 1'b1; limit = 8'd5; reps = 4'd1;
        step();
        go = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t6_abrt_from_clr", 32'(dut_outs()), 32'({5'b10100, 4'd0}));
        step();
        chk("t6_idle", 32'(dut_outs()), 32'd0);

        // Watchdog: counter stalls at 7, limit 20
        stall_en = 1'b1; stall_val = 8'd7;
        go = 1'b1; limit = 8'd20; reps = 4'd1;
        step();
        go = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (cnt_q == 8'd7) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        chk("t7_reach7", 32'(ok), 32'd1);
        repeat (16) step();
        chk("t7_before_expiry", 32'({err, cnt_clr, busy}), 32'(3'b001));
        step();
        chk("t7_wdog_abrt", 32'(dut_outs()), 32'({5'b10101, 4'd0}));
        step();
        chk("t7_idle_err", 32'(dut_outs()), 32'({5'b00001, 4'd0}));
        repeat (3) step();
        chk("t7_err_sticky", 32'(err), 32'd1);
        stall_en = 1'b0;
        go = 1'b1; limit = 8'd2; reps = 4'd1;
        step();
        go = 1'b0;
        chk("t7_err_cleared", 32'(dut_outs()), 32'({5'b10100, 4'd0}));
        run_to_idle("t7", dones);
        chk("t7_dones", 32'(dones), 32'd1);

        // Reset during WAIT of pass 2 of 3
        go = 1'b1; limit = 8'd3; reps = 4'd3;
        step();
        go = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (rep_cnt == 4'd1 && busy && !cnt_clr && !cnt_start) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        chk("t8_in_pass2", 32'(ok), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t8_async_reset", 32'(dut_outs()), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("t8_idle", 32'(dut_outs()), 32'd0);
        go = 1'b1; limit = 8'd2; reps = 4'd1;
        step();
        go = 1'b0;
        chk("t8_restart", 32'(dut_outs()), 32'({5'b10100, 4'd0}));
        run_to_idle("t8", dones);
        chk("t8_dones", 32'(dones), 32'd1);
        chk("t8_rep", 32'(rep_cnt), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
